// File: rtl/dispatch_sched_pkg.sv
// Shared types for the dispatch scheduler: default sizing, thread-id type and FSM encoding.
package types;

  localparam int unsigned NUM_Threads = 4;
  localparam int unsigned NUM_ALUs    = 4;
  localparam int unsigned TID_W       = 3;

  typedef logic [TID_W-1:0] tid_t;

  // Thread id shown on an ALU slot that carries no live thread.
  localparam tid_t TID_NONE = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/dispatch_sched_rr_arbiter.sv
// Combinational slot selection: starved ready threads first (ascending id),
// then the remaining ready threads in round-robin order from i_rr_ptr.
module rr_arbiter
  import types::*;
#(
  parameter int unsigned NUM_Threads = types::NUM_Threads,
  parameter int unsigned NUM_ALUs    = types::NUM_ALUs
) (
  input  logic [NUM_Threads-1:0]    i_ready,
  input  logic [NUM_Threads-1:0]    i_starved,
  input  logic [1:0]                i_rr_ptr,
  output logic [NUM_ALUs-1:0]       o_slot_valid,
  output logic [TID_W*NUM_ALUs-1:0] o_slot_tid,
  output logic [NUM_Threads-1:0]    o_granted,
  output logic [1:0]                o_next_ptr
);

  // Each ready thread gets a rank in grant order; the first NUM_ALUs ranks win
  // and rank s lands in slot s, so slots fill from ALU 0 with no duplicates.
  always_comb begin
    int unsigned n_starved;
    int unsigned n_ready;
    int unsigned n_grant;
    int unsigned rp;
    int unsigned dist_i;
    int unsigned dist_j;
    int unsigned pos [NUM_Threads];
    logic [NUM_Threads-1:0] eff_starved;

    o_slot_valid = '0;
    o_slot_tid   = {NUM_ALUs{TID_NONE}};
    o_granted    = '0;
    o_next_ptr   = i_rr_ptr;
    eff_starved  = i_ready & i_starved;
    rp           = 32'(i_rr_ptr);
    n_starved    = 0;
    n_ready      = 0;
    dist_i       = 0;
    dist_j       = 0;

    for (int unsigned i = 0; i < NUM_Threads; i++) begin
      pos[i] = 0;
      if (eff_starved[i]) n_starved++;
      if (i_ready[i])     n_ready++;
    end

    for (int unsigned i = 0; i < NUM_Threads; i++) begin
      if (eff_starved[i]) begin
        for (int unsigned j = 0; j < NUM_Threads; j++) begin
          if (j < i && eff_starved[j]) pos[i]++;
        end
      end else begin
        pos[i] = n_starved;
        dist_i = (i + NUM_Threads - rp) % NUM_Threads;
        for (int unsigned j = 0; j < NUM_Threads; j++) begin
          dist_j = (j + NUM_Threads - rp) % NUM_Threads;
          if (i_ready[j] && !eff_starved[j] && dist_j < dist_i) pos[i]++;
        end
      end
      o_granted[i] = i_ready[i] && (pos[i] < NUM_ALUs);
    end

    for (int unsigned s = 0; s < NUM_ALUs; s++) begin
      for (int unsigned i = 0; i < NUM_Threads; i++) begin
        if (o_granted[i] && pos[i] == s) begin
          o_slot_valid[s]               = 1'b1;
          o_slot_tid[TID_W*s +: TID_W]  = tid_t'(i);
        end
      end
    end

    n_grant = (n_ready < NUM_ALUs) ? n_ready : NUM_ALUs;
    if (n_grant > 0) begin
      for (int unsigned i = 0; i < NUM_Threads; i++) begin
        if (o_granted[i] && pos[i] == n_grant - 1)
          o_next_ptr = 2'((i + 1) % NUM_Threads);
      end
    end
  end

endmodule

// File: rtl/dispatch_sched.sv
// Multi-thread ALU dispatch scheduler: IDLE/RUN/DRAIN control, registered
// slot grants, round-robin pointer and per-thread starvation counters.
module dispatch_sched
  import types::*;
#(
  parameter int unsigned NUM_Threads  = types::NUM_Threads,
  parameter int unsigned NUM_ALUs     = types::NUM_ALUs,
  parameter int unsigned STARVE_LIMIT = 7,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_Threads-1:0]    thread_en,
  input  logic [NUM_Threads-1:0]    hold,
  input  logic                      halt_req,
  output logic [TID_W*NUM_ALUs-1:0] dispatch_threads,
  output logic [NUM_ALUs-1:0]       alu_valid,
  output logic [1:0]                rr_ptr,
  output logic [1:0]                sched_state,
  output logic                      halted
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  sched_state_e                     r_state;
  logic [NUM_ALUs-1:0]              r_valid;
  logic [TID_W*NUM_ALUs-1:0]        r_tid;
  logic [1:0]                       r_rr;
  logic [NUM_Threads-1:0][CW-1:0]   r_starve;
  logic [DW-1:0]                    r_drain;
  logic                             r_halted;

  sched_state_e                     w_state_nxt;
  logic                             w_issue;
  logic                             w_drain_last;
  logic [NUM_Threads-1:0]           w_ready;
  logic [NUM_Threads-1:0]           w_starved;
  logic [NUM_Threads-1:0][CW-1:0]   w_starve_nxt;
  logic [NUM_ALUs-1:0]              w_slot_valid;
  logic [TID_W*NUM_ALUs-1:0]        w_slot_tid;
  logic [NUM_Threads-1:0]           w_granted;
  logic [1:0]                       w_next_ptr;

  assign w_ready = thread_en & ~hold;

  always_comb begin
    w_starved    = '0;
    w_starve_nxt = r_starve;
    for (int unsigned i = 0; i < NUM_Threads; i++) begin
      w_starved[i] = (r_starve[i] == CW'(STARVE_LIMIT));
      if (!w_ready[i] || w_granted[i])
        w_starve_nxt[i] = '0;
      else if (!w_starved[i])
        w_starve_nxt[i] = r_starve[i] + 1'b1;
    end
  end

  rr_arbiter #(
    .NUM_Threads (NUM_Threads),
    .NUM_ALUs    (NUM_ALUs)
  ) u_arb (
    .i_ready      (w_ready),
    .i_starved    (w_starved),
    .i_rr_ptr     (r_rr),
    .o_slot_valid (w_slot_valid),
    .o_slot_tid   (w_slot_tid),
    .o_granted    (w_granted),
    .o_next_ptr   (w_next_ptr)
  );

  // halt_req is tested before issue so it wins over any grant in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_drain_last = (r_drain == DW'(DRAIN_CYCLES - 1));
    unique case (r_state)
      ST_IDLE: begin
        if (|thread_en && !halt_req) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_issue = 1'b1;
          if (thread_en == '0) w_state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_drain_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_valid  <= '0;
      r_tid    <= {NUM_ALUs{TID_NONE}};
      r_rr     <= '0;
      r_starve <= '0;
      r_drain  <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_issue) begin
        r_valid  <= w_slot_valid;
        r_tid    <= w_slot_tid;
        r_rr     <= w_next_ptr;
        r_starve <= w_starve_nxt;
      end else begin
        r_valid <= '0;
        r_tid   <= {NUM_ALUs{TID_NONE}};
      end

      if (r_state == ST_DRAIN)
        r_drain <= w_drain_last ? '0 : r_drain + 1'b1;
      else
        r_drain <= '0;

      if (r_state == ST_DRAIN && w_drain_last)
        r_halted <= 1'b1;
      else if (r_state != ST_RUN && w_state_nxt == ST_RUN)
        r_halted <= 1'b0;
    end
  end

  assign dispatch_threads = r_tid;
  assign alu_valid        = r_valid;
  assign rr_ptr           = r_rr;
  assign sched_state      = r_state;
  assign halted           = r_halted;

endmodule

// File: tb/tb_dispatch_sched.sv
// Scoreboard bench: three scheduler configurations share random stimulus and
// are checked every cycle against a queue-based reference model.
module tb_dispatch_sched;

  typedef struct packed {
    logic [3:0]  v;
    logic [11:0] id;
    logic [1:0]  rr;
    logic [1:0]  st;
    logic        halted;
  } exp_t;

  typedef struct packed {
    exp_t c2;
    exp_t c1;
    exp_t c0;
  } exp_all_t;

  logic        clk;
  logic        rst;
  logic        halt_req;
  logic [3:0]  thread_en;
  logic [3:0]  hold;

  logic [11:0] d4;  logic [3:0] v4;  logic [1:0] rr4, st4;  logic h4;
  logic [5:0]  d2;  logic [1:0] v2;  logic [1:0] rr2, st2;  logic h2;
  logic [2:0]  d1;  logic [0:0] v1;  logic [1:0] rr1, st1;  logic h1;

  int n_total;
  int n_bad;

  exp_all_t sb_q[$];

  int m_st[3];
  int m_rr[3];
  int m_drain[3];
  int m_cnt[3][4];
  bit m_halted[3];

  dispatch_sched #(.NUM_Threads(4), .NUM_ALUs(4), .STARVE_LIMIT(7), .DRAIN_CYCLES(3)) u_alu4 (
    .clk(clk), .rst(rst), .thread_en(thread_en), .hold(hold), .halt_req(halt_req),
    .dispatch_threads(d4), .alu_valid(v4), .rr_ptr(rr4), .sched_state(st4), .halted(h4));

  dispatch_sched #(.NUM_Threads(4), .NUM_ALUs(2), .STARVE_LIMIT(7), .DRAIN_CYCLES(3)) u_alu2 (
    .clk(clk), .rst(rst), .thread_en(thread_en), .hold(hold), .halt_req(halt_req),
    .dispatch_threads(d2), .alu_valid(v2), .rr_ptr(rr2), .sched_state(st2), .halted(h2));

  dispatch_sched #(.NUM_Threads(4), .NUM_ALUs(1), .STARVE_LIMIT(2), .DRAIN_CYCLES(3)) u_alu1 (
    .clk(clk), .rst(rst), .thread_en(thread_en), .hold(hold), .halt_req(halt_req),
    .dispatch_threads(d1), .alu_valid(v1), .rr_ptr(rr1), .sched_state(st1), .halted(h1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int alu_of(int c);
    return (c == 0) ? 4 : (c == 1) ? 2 : 1;
  endfunction

  function automatic int lim_of(int c);
    return (c == 2) ? 2 : 7;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 3; c++) begin
      m_st[c] = 0; m_rr[c] = 0; m_drain[c] = 0; m_halted[c] = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[c][i] = 0;
    end
  endfunction

  function automatic exp_t snapshot(int c, int sid[4], bit sv[4]);
    exp_t e;
    e.v      = {sv[3], sv[2], sv[1], sv[0]};
    e.id     = {3'(sid[3]), 3'(sid[2]), 3'(sid[1]), 3'(sid[0])};
    e.rr     = 2'(m_rr[c]);
    e.st     = 2'(m_st[c]);
    e.halted = m_halted[c];
    return e;
  endfunction

  // One clock of a single configuration, written from the scheduling rules.
  function automatic exp_t model_step(int c, logic [3:0] en, logic [3:0] hd, logic hr);
    int order[$];
    int sid[4];
    bit sv[4];
    bit rdy[4];
    bit got[4];
    int lim;
    lim = lim_of(c);
    for (int i = 0; i < 4; i++) begin
      sid[i] = 7; sv[i] = 1'b0; got[i] = 1'b0;
      rdy[i] = en[i] && !hd[i];
    end
    case (m_st[c])
      0: begin
        if (en != 4'b0 && !hr) begin
          m_st[c] = 1;
          m_halted[c] = 1'b0;
        end
      end
      1: begin
        if (hr) begin
          m_st[c] = 2;
          m_drain[c] = 3;
        end else begin
          for (int i = 0; i < 4; i++)
            if (rdy[i] && m_cnt[c][i] == lim) order.push_back(i);
          for (int k = 0; k < 4; k++) begin
            int t;
            t = (m_rr[c] + k) % 4;
            if (rdy[t] && m_cnt[c][t] != lim) order.push_back(t);
          end
          while (order.size() > alu_of(c)) void'(order.pop_back());
          for (int s = 0; s < order.size(); s++) begin
            sid[s] = order[s]; sv[s] = 1'b1; got[order[s]] = 1'b1;
          end
          for (int i = 0; i < 4; i++) begin
            if (!rdy[i] || got[i]) m_cnt[c][i] = 0;
            else if (m_cnt[c][i] < lim) m_cnt[c][i]++;
          end
          if (order.size() > 0) m_rr[c] = (order[order.size()-1] + 1) % 4;
          if (en == 4'b0) m_st[c] = 0;
        end
      end
      default: begin
        m_drain[c]--;
        if (m_drain[c] == 0) begin
          m_st[c] = 0;
          m_halted[c] = 1'b1;
        end
      end
    endcase
    return snapshot(c, sid, sv);
  endfunction

  function automatic exp_all_t step_all(logic [3:0] en, logic [3:0] hd, logic hr);
    exp_all_t e;
    if (!rst) model_reset();
    e.c0 = rst ? model_step(0, en, hd, hr) : reset_exp();
    e.c1 = rst ? model_step(1, en, hd, hr) : reset_exp();
    e.c2 = rst ? model_step(2, en, hd, hr) : reset_exp();
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.v = 4'b0; e.id = 12'hFFF; e.rr = 2'd0; e.st = 2'd0; e.halted = 1'b0;
    return e;
  endfunction

  function automatic void cmp(int c, exp_t a, exp_t e);
    n_total++;
    if (a.v !== e.v || a.id !== e.id) begin
      n_bad++;
      $display("FAIL slots cfg%0d t=%0t: got valid=%b ids=%h, want valid=%b ids=%h",
               c, $time, a.v, a.id, e.v, e.id);
    end
    n_total++;
    if (a.rr !== e.rr) begin
      n_bad++;
      $display("FAIL rr_ptr cfg%0d t=%0t: got %0d, want %0d", c, $time, a.rr, e.rr);
    end
    n_total++;
    if (a.st !== e.st) begin
      n_bad++;
      $display("FAIL sched_state cfg%0d t=%0t: got %0d, want %0d", c, $time, a.st, e.st);
    end
    n_total++;
    if (a.halted !== e.halted) begin
      n_bad++;
      $display("FAIL halted cfg%0d t=%0t: got %b, want %b", c, $time, a.halted, e.halted);
    end
  endfunction

  function automatic void check_all(exp_all_t e);
    cmp(0, {v4, d4, rr4, st4, h4}, e.c0);
    cmp(1, {2'b00, v2, 6'h3F, d2, rr2, st2, h2}, e.c1);
    cmp(2, {3'b000, v1, 9'h1FF, d1, rr1, st1, h1}, e.c2);
  endfunction

  task automatic tick(input logic [3:0] en, input logic [3:0] hd, input logic hr);
    exp_all_t e;
    thread_en = en;
    hold      = hd;
    halt_req  = hr;
    e = step_all(en, hd, hr);
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  // Entered 1 time unit after a rising edge; reset lands between edges.
  task automatic mid_reset();
    exp_all_t e;
    #6;
    rst = 1'b0;
    model_reset();
    #1;
    e.c0 = reset_exp(); e.c1 = reset_exp(); e.c2 = reset_exp();
    check_all(e);
    tick(thread_en, hold, 1'b0);
    #3;
    rst = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) check_all(sb_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running, want done");
    $fatal(1);
  end

  initial begin
    exp_all_t e0;
    logic [3:0] en_r;
    logic [3:0] hd_r;
    logic       hr_r;
    int         sel;
    n_total   = 0;
    n_bad     = 0;
    thread_en = 4'b0;
    hold      = 4'b0;
    halt_req  = 1'b0;
    rst       = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    #1;
    e0.c0 = reset_exp(); e0.c1 = reset_exp(); e0.c2 = reset_exp();
    check_all(e0);
    #1 rst = 1'b1;

    tick(4'h0, 4'h0, 1'b0);
    tick(4'hF, 4'h0, 1'b0);
    repeat (3) tick(4'hF, 4'h0, 1'b0);
    repeat (2) tick(4'hF, 4'b0100, 1'b0);
    tick(4'hF, 4'h0, 1'b1);
    repeat (4) tick(4'hF, 4'h0, 1'b0);
    tick(4'hF, 4'h0, 1'b1);
    repeat (3) tick(4'hF, 4'h0, 1'b1);
    repeat (3) tick(4'hF, 4'h0, 1'b1);
    tick(4'hF, 4'h0, 1'b0);
    repeat (12) tick(4'hF, 4'h0, 1'b0);
    mid_reset();
    repeat (4) tick(4'hF, 4'h0, 1'b0);
    tick(4'h0, 4'h0, 1'b0);
    tick(4'h0, 4'h0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 19);
      en_r = (sel == 0) ? 4'h0 : (sel < 5) ? 4'($urandom) : 4'hF;
      hd_r = 4'($urandom) & 4'($urandom) & 4'($urandom);
      hr_r = ($urandom_range(0, 14) == 0);
      tick(en_r, hd_r, hr_r);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    @(negedge clk);
    #1;
    n_total++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
